id_exe_reg: RTL and testbench
=============================

# id_exe_reg

ID/EXE pipeline register of the ARM pipeline. It captures the decode-stage control word from the control unit, the decode-stage operands, the PC and the destination tag on each rising clock edge, and presents them to the execute stage one cycle later. It implements three pipeline actions: branch flush, hazard bubble insertion and whole-pipe freeze. It also keeps a valid bit, so downstream forwarding and hazard logic can ignore bubbles.

## Interface
Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, register operand width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- freezeIn  in  1  memory-stall freeze; hold all state
- flushIn  in  1  branch taken in EXE; load a bubble
- hazardIn  in  1  RAW hazard detected in ID; load a bubble
- EXE_CMDIn  in  4  ALU command from control unit
- MEM_R_ENIn, MEM_W_ENIn, WB_ENIn, BIn, SIn  in  1 each  control bits from control unit
- PCIn  in  ADDR_W  PC+4 of the decoded instruction
- Val_RnIn, Val_RmIn  in  DATA_W  register-file read data
- immIn  in  1  I bit
- shiftOperandIn  in  12  shifter operand field
- signedImm24In  in  24  branch offset
- destIn  in  4  Rd
- src1In, src2In  in  4  Rn / Rm tags, for forwarding
- carryIn  in  1  status-register C flag sampled in ID
- every input above except clk, rst, freezeIn, flushIn and hazardIn has a same-width registered output with the suffix In replaced by Out
- validOut  out  1  1 = real instruction in EXE, 0 = bubble

## Operation
Each rising edge selects exactly one action. Priority, highest first:

1. rst low (asynchronous):
   - all outputs go to 0, including validOut
   - this takes effect immediately, not at the next edge
2. flushIn = 1: load a bubble.
   - EXE_CMDOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut, BOut, SOut and validOut all become 0
   - every data field (PC, Val_Rn, Val_Rm, imm, shiftOperand, signedImm24, dest, src1, src2, carry) becomes 0
   - flushIn takes precedence even when freezeIn = 1
3. freezeIn = 1 (and flushIn = 0): hold.
   - every register keeps its value, including validOut
   - hazardIn is ignored
4. hazardIn = 1 (and flushIn = 0, freezeIn = 0): load a bubble, identical to case 2.
   - the instruction presented at the inputs is not lost; upstream stages are stalled and present it again next cycle
5. Otherwise: normal load.
   - every Out field takes its In value
   - validOut becomes 1

Bubble rules:
- A bubble must never write the register file or memory, never branch and never update status.
- These guarantees come from the five zeroed control bits.
- EXE_CMD 0 is the no-op encoding.

Other rules:
- No arithmetic is performed and no widths change; all fields pass through bit-exact.
- Outputs are register outputs only; there is no combinational path from any input to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear at the outputs after edge N.
- Throughput: 1 instruction per cycle when no control input is asserted.
- Reset release: the first edge with rst high and no control input asserted loads the inputs.
- Freeze: may be held for any number of cycles. The outputs stay constant throughout, and loading resumes on the first edge after freezeIn drops.
- Back-to-back flush: consecutive flush cycles produce consecutive bubbles.
- Hazard: while hazardIn stays high, bubbles are produced every cycle.
- Reset mid-freeze: reset clears the register. After release the register is empty (validOut = 0) until the next normal load.
- Control inputs are synchronous: flushIn, freezeIn and hazardIn only matter at rising edges.

## Test plan
- Reset: drive all inputs to nonzero values and pull rst low between edges. All outputs must read 0 immediately, before the next edge. After release, one edge with WB_ENIn = 1, EXE_CMDIn = 4'b0010, destIn = 4'd3 → WB_ENOut = 1, EXE_CMDOut = 4'b0010, destOut = 3, validOut = 1.
- Streaming: load three instructions on consecutive edges, with PCIn = 4, 8, 12 and Val_RnIn = 32'hA5A5_0001, 0002, 0003. The outputs must follow with exactly one cycle of lag.
- Freeze: after loading PC = 8, hold freezeIn = 1 for 3 edges while the inputs change to PC = 12 and MEM_W_ENIn = 1. PCOut must stay 8 and MEM_W_ENOut must stay 0 for all 3 edges. The edge after release loads PC = 12.
- Hazard bubble: with valid inputs WB_ENIn = 1, MEM_R_ENIn = 1, destIn = 5, assert hazardIn for 1 edge. Expect WB_ENOut = 0, MEM_R_ENOut = 0, destOut = 0, validOut = 0. The next edge, with hazardIn = 0, loads dest = 5 with WB_ENOut = 1.
- Flush with freeze: assert flushIn = 1 and freezeIn = 1 together while the register holds BOut = 1 and SOut = 1. Expect a bubble: BOut = 0, SOut = 0, validOut = 0.
- Freeze with hazard: assert freezeIn = 1 and hazardIn = 1 together. Expect every output unchanged, with no bubble inserted.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded control word, operands, PC and
// tags, and supports branch flush, hazard bubble insertion and whole-pipe freeze.
module id_exe_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freezeIn,
  input  logic              flushIn,
  input  logic              hazardIn,
  input  logic [3:0]        EXE_CMDIn,
  input  logic              MEM_R_ENIn,
  input  logic              MEM_W_ENIn,
  input  logic              WB_ENIn,
  input  logic              BIn,
  input  logic              SIn,
  input  logic [ADDR_W-1:0] PCIn,
  input  logic [DATA_W-1:0] Val_RnIn,
  input  logic [DATA_W-1:0] Val_RmIn,
  input  logic              immIn,
  input  logic [11:0]       shiftOperandIn,
  input  logic [23:0]       signedImm24In,
  input  logic [3:0]        destIn,
  input  logic [3:0]        src1In,
  input  logic [3:0]        src2In,
  input  logic              carryIn,
  output logic [3:0]        EXE_CMDOut,
  output logic              MEM_R_ENOut,
  output logic              MEM_W_ENOut,
  output logic              WB_ENOut,
  output logic              BOut,
  output logic              SOut,
  output logic [ADDR_W-1:0] PCOut,
  output logic [DATA_W-1:0] Val_RnOut,
  output logic [DATA_W-1:0] Val_RmOut,
  output logic              immOut,
  output logic [11:0]       shiftOperandOut,
  output logic [23:0]       signedImm24Out,
  output logic [3:0]        destOut,
  output logic [3:0]        src1Out,
  output logic [3:0]        src2Out,
  output logic              carryOut,
  output logic              validOut
);

  // Everything carried from ID to EXE, plus the valid bit that marks bubbles.
  typedef struct packed {
    logic [3:0]        exe_cmd;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              wb_en;
    logic              b;
    logic              s;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              carry;
    logic              valid;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE
  } action_e;

  stage_t  stage_in;
  stage_t  stage_q;
  stage_t  stage_next;
  action_e action;

  always_comb begin
    stage_in.exe_cmd       = EXE_CMDIn;
    stage_in.mem_r_en      = MEM_R_ENIn;
    stage_in.mem_w_en      = MEM_W_ENIn;
    stage_in.wb_en         = WB_ENIn;
    stage_in.b             = BIn;
    stage_in.s             = SIn;
    stage_in.pc            = PCIn;
    stage_in.val_rn        = Val_RnIn;
    stage_in.val_rm        = Val_RmIn;
    stage_in.imm           = immIn;
    stage_in.shift_operand = shiftOperandIn;
    stage_in.signed_imm24  = signedImm24In;
    stage_in.dest          = destIn;
    stage_in.src1          = src1In;
    stage_in.src2          = src2In;
    stage_in.carry         = carryIn;
    stage_in.valid         = 1'b1;
  end

  // Flush outranks freeze: a taken branch must squash the slot even while the
  // rest of the pipe is stalled. Freeze outranks hazard so a stall is not
  // turned into a lost instruction.
  always_comb begin
    if (flushIn) begin
      action = ACT_BUBBLE;
    end else if (freezeIn) begin
      action = ACT_HOLD;
    end else if (hazardIn) begin
      action = ACT_BUBBLE;
    end else begin
      action = ACT_LOAD;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // stage_next unassigned, which would otherwise infer a latch.
    stage_next = stage_q;
    case (action)
      ACT_LOAD:   stage_next = stage_in;
      ACT_BUBBLE: stage_next = '0;
      default:    stage_next = stage_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for all sequential state so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_next;
    end
  end

  assign EXE_CMDOut      = stage_q.exe_cmd;
  assign MEM_R_ENOut     = stage_q.mem_r_en;
  assign MEM_W_ENOut     = stage_q.mem_w_en;
  assign WB_ENOut        = stage_q.wb_en;
  assign BOut            = stage_q.b;
  assign SOut            = stage_q.s;
  assign PCOut           = stage_q.pc;
  assign Val_RnOut       = stage_q.val_rn;
  assign Val_RmOut       = stage_q.val_rm;
  assign immOut          = stage_q.imm;
  assign shiftOperandOut = stage_q.shift_operand;
  assign signedImm24Out  = stage_q.signed_imm24;
  assign destOut         = stage_q.dest;
  assign src1Out         = stage_q.src1;
  assign src2Out         = stage_q.src2;
  assign carryOut        = stage_q.carry;
  assign validOut        = stage_q.valid;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed testbench for id_exe_reg: reset, streaming, freeze, hazard and
// flush scenarios with hand-computed expectations.
module tb_id_exe_reg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              freezeIn, flushIn, hazardIn;
  logic [3:0]        EXE_CMDIn;
  logic              MEM_R_ENIn, MEM_W_ENIn, WB_ENIn, BIn, SIn;
  logic [ADDR_W-1:0] PCIn;
  logic [DATA_W-1:0] Val_RnIn, Val_RmIn;
  logic              immIn;
  logic [11:0]       shiftOperandIn;
  logic [23:0]       signedImm24In;
  logic [3:0]        destIn, src1In, src2In;
  logic              carryIn;
  logic [3:0]        EXE_CMDOut;
  logic              MEM_R_ENOut, MEM_W_ENOut, WB_ENOut, BOut, SOut;
  logic [ADDR_W-1:0] PCOut;
  logic [DATA_W-1:0] Val_RnOut, Val_RmOut;
  logic              immOut;
  logic [11:0]       shiftOperandOut;
  logic [23:0]       signedImm24Out;
  logic [3:0]        destOut, src1Out, src2Out;
  logic              carryOut;
  logic              validOut;

  int total_cnt = 0;
  int pass_cnt  = 0;

  id_exe_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .freezeIn(freezeIn), .flushIn(flushIn), .hazardIn(hazardIn),
    .EXE_CMDIn(EXE_CMDIn), .MEM_R_ENIn(MEM_R_ENIn), .MEM_W_ENIn(MEM_W_ENIn),
    .WB_ENIn(WB_ENIn), .BIn(BIn), .SIn(SIn), .PCIn(PCIn),
    .Val_RnIn(Val_RnIn), .Val_RmIn(Val_RmIn), .immIn(immIn),
    .shiftOperandIn(shiftOperandIn), .signedImm24In(signedImm24In),
    .destIn(destIn), .src1In(src1In), .src2In(src2In), .carryIn(carryIn),
    .EXE_CMDOut(EXE_CMDOut), .MEM_R_ENOut(MEM_R_ENOut), .MEM_W_ENOut(MEM_W_ENOut),
    .WB_ENOut(WB_ENOut), .BOut(BOut), .SOut(SOut), .PCOut(PCOut),
    .Val_RnOut(Val_RnOut), .Val_RmOut(Val_RmOut), .immOut(immOut),
    .shiftOperandOut(shiftOperandOut), .signedImm24Out(signedImm24Out),
    .destOut(destOut), .src1Out(src1Out), .src2Out(src2Out), .carryOut(carryOut),
    .validOut(validOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    freezeIn = 0; flushIn = 0; hazardIn = 0;
    EXE_CMDIn = '0; MEM_R_ENIn = 0; MEM_W_ENIn = 0; WB_ENIn = 0; BIn = 0; SIn = 0;
    PCIn = '0; Val_RnIn = '0; Val_RmIn = '0; immIn = 0;
    shiftOperandIn = '0; signedImm24In = '0;
    destIn = '0; src1In = '0; src2In = '0; carryIn = 0;
  endtask

  task automatic set_all_nonzero();
    EXE_CMDIn = 4'hF; MEM_R_ENIn = 1; MEM_W_ENIn = 1; WB_ENIn = 1; BIn = 1; SIn = 1;
    PCIn = 32'hDEAD_BEEF; Val_RnIn = 32'h1234_5678; Val_RmIn = 32'h8765_4321;
    immIn = 1; shiftOperandIn = 12'hABC; signedImm24In = 24'h89ABCD;
    destIn = 4'hE; src1In = 4'hD; src2In = 4'hC; carryIn = 1;
  endtask

  function automatic logic [179:0] all_outputs();
    return {EXE_CMDOut, MEM_R_ENOut, MEM_W_ENOut, WB_ENOut, BOut, SOut, PCOut,
            Val_RnOut, Val_RmOut, immOut, shiftOperandOut, signedImm24Out,
            destOut, src1Out, src2Out, carryOut, validOut};
  endfunction

  task automatic test_reset();
    logic [179:0] loaded;
    logic [179:0] exp_loaded;
    clear_inputs();
    set_all_nonzero();
    tick();
    // A full normal load first so the asynchronous clear has something to clear.
    loaded     = all_outputs();
    exp_loaded = {4'hF, 5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8765_4321,
                  1'b1, 12'hABC, 24'h89ABCD, 4'hE, 4'hD, 4'hC, 1'b1, 1'b1};
    total_cnt++;
    if (loaded !== exp_loaded) $display("FAIL reset_preload got=%h exp=%h", loaded, exp_loaded);
    else pass_cnt++;
    #2 rst = 0;
    #1;
    total_cnt++;
    if (all_outputs() !== '0) $display("FAIL reset_async got=%h exp=0", all_outputs());
    else pass_cnt++;
    tick();
    clear_inputs();
    rst = 1;
    WB_ENIn = 1; EXE_CMDIn = 4'b0010; destIn = 4'd3;
    tick();
    total_cnt++;
    if ({WB_ENOut, EXE_CMDOut, destOut, validOut} !== {1'b1, 4'b0010, 4'd3, 1'b1})
      $display("FAIL reset_release_load got wb=%b cmd=%h dest=%0d v=%b exp wb=1 cmd=2 dest=3 v=1",
               WB_ENOut, EXE_CMDOut, destOut, validOut);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [31:0] prev_pc;
    clear_inputs();
    prev_pc = PCOut;
    for (int i = 0; i < 3; i++) begin
      PCIn     = 32'(4 * (i + 1));
      Val_RnIn = 32'hA5A5_0001 + 32'(i);
      #3;
      total_cnt++;
      if (PCOut !== prev_pc) $display("FAIL stream_lag%0d pc got=%h exp=%h", i, PCOut, prev_pc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({PCOut, Val_RnOut, validOut} !== {32'(4 * (i + 1)), 32'hA5A5_0001 + 32'(i), 1'b1})
        $display("FAIL stream%0d got pc=%h rn=%h v=%b exp pc=%h rn=%h v=1", i, PCOut, Val_RnOut,
                 validOut, 32'(4 * (i + 1)), 32'hA5A5_0001 + 32'(i));
      else pass_cnt++;
      prev_pc = 32'(4 * (i + 1));
    end
  endtask

  task automatic test_freeze();
    clear_inputs();
    PCIn = 32'd8;
    tick();
    PCIn = 32'd12; MEM_W_ENIn = 1; freezeIn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({PCOut, MEM_W_ENOut, validOut} !== {32'd8, 1'b0, 1'b1})
        $display("FAIL freeze_hold%0d got pc=%h mw=%b v=%b exp pc=8 mw=0 v=1", i, PCOut,
                 MEM_W_ENOut, validOut);
      else pass_cnt++;
    end
    freezeIn = 0;
    tick();
    total_cnt++;
    if ({PCOut, MEM_W_ENOut} !== {32'd12, 1'b1})
      $display("FAIL freeze_release got pc=%h mw=%b exp pc=c mw=1", PCOut, MEM_W_ENOut);
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    clear_inputs();
    WB_ENIn = 1; MEM_R_ENIn = 1; destIn = 4'd5; hazardIn = 1;
    tick();
    total_cnt++;
    if ({WB_ENOut, MEM_R_ENOut, destOut, validOut} !== {1'b0, 1'b0, 4'd0, 1'b0})
      $display("FAIL hazard_bubble got wb=%b mr=%b dest=%0d v=%b exp all 0", WB_ENOut,
               MEM_R_ENOut, destOut, validOut);
    else pass_cnt++;
    hazardIn = 0;
    tick();
    total_cnt++;
    if ({WB_ENOut, MEM_R_ENOut, destOut, validOut} !== {1'b1, 1'b1, 4'd5, 1'b1})
      $display("FAIL hazard_reload got wb=%b mr=%b dest=%0d v=%b exp wb=1 mr=1 dest=5 v=1",
               WB_ENOut, MEM_R_ENOut, destOut, validOut);
    else pass_cnt++;
  endtask

  task automatic test_flush_freeze();
    clear_inputs();
    BIn = 1; SIn = 1; PCIn = 32'h40;
    tick();
    total_cnt++;
    if ({BOut, SOut, validOut} !== 3'b111)
      $display("FAIL flush_preload got b=%b s=%b v=%b exp 111", BOut, SOut, validOut);
    else pass_cnt++;
    flushIn = 1; freezeIn = 1;
    tick();
    total_cnt++;
    if ({BOut, SOut, validOut, PCOut} !== {3'b000, 32'd0})
      $display("FAIL flush_over_freeze got b=%b s=%b v=%b pc=%h exp all 0", BOut, SOut,
               validOut, PCOut);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_all_nonzero();
    flushIn = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (all_outputs() !== '0) $display("FAIL flush_b2b%0d got=%h exp=0", i, all_outputs());
      else pass_cnt++;
    end
    flushIn = 0;
    tick();
    total_cnt++;
    if ({validOut, Val_RmOut} !== {1'b1, 32'h8765_4321})
      $display("FAIL flush_resume got v=%b rm=%h exp v=1 rm=87654321", validOut, Val_RmOut);
    else pass_cnt++;
  endtask

  task automatic test_freeze_hazard();
    clear_inputs();
    PCIn = 32'h100; destIn = 4'd7; WB_ENIn = 1; src2In = 4'd9;
    tick();
    clear_inputs();
    PCIn = 32'h200; destIn = 4'd1;
    freezeIn = 1; hazardIn = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if ({PCOut, destOut, WB_ENOut, src2Out, validOut} !== {32'h100, 4'd7, 1'b1, 4'd9, 1'b1})
        $display("FAIL freeze_hazard%0d got pc=%h dest=%0d wb=%b src2=%0d v=%b exp pc=100 dest=7 wb=1 src2=9 v=1",
                 i, PCOut, destOut, WB_ENOut, src2Out, validOut);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_freeze();
    clear_inputs();
    PCIn = 32'h300;
    tick();
    freezeIn = 1;
    #2 rst = 0;
    #2 rst = 1;
    tick();
    total_cnt++;
    if ({validOut, PCOut} !== {1'b0, 32'd0})
      $display("FAIL reset_mid_freeze got v=%b pc=%h exp v=0 pc=0", validOut, PCOut);
    else pass_cnt++;
    freezeIn = 0;
    tick();
    total_cnt++;
    if ({validOut, PCOut} !== {1'b1, 32'h300})
      $display("FAIL reset_mid_freeze_load got v=%b pc=%h exp v=1 pc=300", validOut, PCOut);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    repeat (2) tick();
    rst = 1;
    test_reset();
    test_streaming();
    test_freeze();
    test_hazard();
    test_flush_freeze();
    test_back_to_back();
    test_freeze_hazard();
    test_reset_mid_freeze();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
